// File: rtl/alu_writeback_stage_pkg.sv
// rtl/alu_writeback_stage_pkg.sv - shared condition codes, flag indices and opcodes
package alu_writeback_stage_pkg;

  typedef logic [3:0] flags_t;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  localparam logic [4:0] OP_TST = 5'd8;
  localparam logic [4:0] OP_TEQ = 5'd9;
  localparam logic [4:0] OP_CMP = 5'd10;
  localparam logic [4:0] OP_CMN = 5'd11;

  // Compare-class ops update flags even without the S bit
  function automatic logic is_compare_op(input logic [4:0] op);
    return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

endpackage

// File: rtl/alu_writeback_stage_if.sv
// rtl/alu_writeback_stage_if.sv - ALU-to-writeback handshake bundle
interface alu_writeback_stage_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        cond;
  logic [4:0]        opcode;
  logic [DATA_W-1:0] alu_result;
  logic [3:0]        alu_flags;
  logic              alu_wb;
  logic              set_flags;
  logic [3:0]        rd;

  modport master (
    output in_valid, cond, opcode, alu_result, alu_flags, alu_wb, set_flags, rd,
    input  in_ready
  );

  modport slave (
    input  in_valid, cond, opcode, alu_result, alu_flags, alu_wb, set_flags, rd,
    output in_ready
  );
endinterface

// File: rtl/arm_cond_check.sv
// rtl/arm_cond_check.sv - ARM condition field evaluation against {V,N,C,Z}
module arm_cond_check
  import alu_writeback_stage_pkg::*;
(
  input  logic [3:0] cond,
  input  flags_t     flags,
  output logic       pass
);

  logic z, c, n, v;
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];

  // Decode the condition field into a single pass/fail
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_writeback_stage.sv
// rtl/alu_writeback_stage.sv - conditional commit of ALU results to RF and CPSR
module alu_writeback_stage
  import alu_writeback_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_writeback_stage_if.slave alu,
  input  logic                 wb_hold,
  input  logic                 flush,
  output logic                 rf_we,
  output logic [3:0]           rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 pc_redirect,
  output logic [3:0]           cpsr_flags,
  output logic [CNT_W-1:0]     retire_cnt,
  output logic [CNT_W-1:0]     skip_cnt
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HELD  = 1'b1;

  logic [0:0]        state;
  logic              s_valid;
  logic [3:0]        s_cond;
  logic [4:0]        s_opcode;
  logic [DATA_W-1:0] s_result;
  flags_t            s_flags;
  logic              s_alu_wb;
  logic              s_set_flags;
  logic [3:0]        s_rd;
  flags_t            cpsr;

  logic pass, accept, go, skip;

  assign s_valid      = (state == ST_HELD);
  assign alu.in_ready = !s_valid | !wb_hold;
  assign accept       = alu.in_valid & alu.in_ready & !flush;
  assign go           = s_valid & pass & !wb_hold & !flush;
  assign skip         = s_valid & !pass & !wb_hold & !flush;

  // The held instruction is judged against flags committed by its predecessor
  arm_cond_check u_cond (
    .cond  (s_cond),
    .flags (cpsr),
    .pass  (pass)
  );

  assign rf_we       = go & s_alu_wb;
  assign rf_waddr    = s_rd;
  assign rf_wdata    = s_result;
  assign pc_redirect = rf_we & (s_rd == 4'd15);
  assign cpsr_flags  = cpsr;

  // Stage register: flush empties, accept refills, completion drains
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_EMPTY;
      s_cond      <= '0;
      s_opcode    <= '0;
      s_result    <= '0;
      s_flags     <= '0;
      s_alu_wb    <= 1'b0;
      s_set_flags <= 1'b0;
      s_rd        <= '0;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else if (accept) begin
      state       <= ST_HELD;
      s_cond      <= alu.cond;
      s_opcode    <= alu.opcode;
      s_result    <= alu.alu_result;
      s_flags     <= alu.alu_flags;
      s_alu_wb    <= alu.alu_wb;
      s_set_flags <= alu.set_flags;
      s_rd        <= alu.rd;
    end else if (s_valid && !wb_hold) begin
      state <= ST_EMPTY;
    end
  end

  // Architectural flags change only when a flag-setting instruction commits
  always_ff @(posedge clk) begin
    if (reset) begin
      cpsr <= '0;
    end else if (go && (s_set_flags || is_compare_op(s_opcode))) begin
      cpsr <= s_flags;
    end
  end

  // Retire/skip counters wrap silently
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt <= '0;
      skip_cnt   <= '0;
    end else begin
      retire_cnt <= retire_cnt + {{(CNT_W-1){1'b0}}, go};
      skip_cnt   <= skip_cnt + {{(CNT_W-1){1'b0}}, skip};
    end
  end

endmodule
